timer_unit_sequencer: RTL and testbench
=======================================

# timer_unit_sequencer

Control sequencer for one timer channel. Drives the control inputs of the channel's prescaler counter and main counter, and consumes the target pulse from each. Generates count ticks from the system clock or from a synchronised reference clock, and handles start/stop/one-shot/continuous modes. Raises a one-cycle interrupt pulse on each main-counter compare match. It sits between the APB register file and the two counter instances.

## Interface
- No parameters.
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  pulse: capture config, restart channel
- stop_i  in  1  pulse: halt counting, go idle
- reset_i  in  1  pulse: clear both counters, go idle
- cfg_presc_en_i  in  1  use prescaler between event source and main counter
- cfg_presc_val_i  in  8  prescaler compare value P; 0 = bypass
- cfg_ref_clk_en_i  in  1  events from ref_clk_i edges instead of every cycle
- cfg_one_shot_i  in  1  stop after first match
- cfg_cmp_clr_i  in  1  clear main counter on match (continuous mode)
- cfg_cmp_i  in  32  main counter compare value
- ref_clk_i  in  1  asynchronous reference clock
- presc_target_i  in  1  prescaler target pulse (registered, one cycle)
- cnt_target_i  in  1  main counter target pulse (registered, one cycle)
- presc_reset_o  out  1  prescaler clear
- presc_enable_o  out  1  prescaler increment
- presc_compare_o  out  32  prescaler compare value, {24'b0, shadow P}
- cnt_reset_o  out  1  main counter clear
- cnt_enable_o  out  1  main counter increment
- cnt_compare_o  out  32  shadow compare value
- irq_o  out  1  registered match pulse
- busy_o  out  1  state is ARM or RUN

## Operation
- States: IDLE, ARM, RUN. Reset: IDLE; all outputs 0; shadows 0; synchroniser flops 0.
- Input priority each cycle: reset_i > stop_i > start_i.
- Any state + reset_i -> IDLE, with presc_reset_o = cnt_reset_o = 1 in the next cycle (one-cycle pulse from a flag flop).
- Any state + stop_i -> IDLE. Counters keep their values.
- Any state + start_i -> ARM. Shadow regs capture cfg_presc_en_i, cfg_presc_val_i, cfg_ref_clk_en_i, cfg_one_shot_i, cfg_cmp_clr_i and cfg_cmp_i. Config changes outside start_i have no effect on a running channel.
- ARM (one cycle): presc_reset_o = cnt_reset_o = 1, enables 0. Next state RUN.
- RUN event: if shadow ref_en, event = rising edge of ref_clk_i through a 2-flop synchroniser plus an edge flop. Otherwise event = 1 every cycle.
- RUN tick:
  - If shadow presc_en and P != 0: presc_enable_o = event, and tick = presc_target_i.
  - Otherwise: tick = event, and presc_enable_o = 0.
- RUN: cnt_enable_o = tick.
- RUN, cnt_target_i = 1:
  - irq_o = 1 in the next cycle.
  - If one_shot: go to IDLE and assert cnt_reset_o that same cycle.
  - Else if cmp_clr: assert cnt_reset_o that same cycle and stay in RUN.
  - Else: stay in RUN; the main counter continues and wraps at 2^32.
- IDLE: all enables 0. presc_target_i and cnt_target_i are ignored; irq_o stays 0.
- busy_o is a combinational decode of the state.

## Timing
- start_i in cycle N: ARM in N+1 (clears asserted), RUN from N+2. First cnt_enable_o in N+2 when no prescaler and no ref clock.
- Ref-clock path latency: ref_clk_i rising edge -> event = 3 clk_i cycles (worst case +1 for metastability).
- Ref-clock constraint: ref_clk_i frequency < clk_i/2. Faster edges may be lost; this is not required to be detected.
- Prescaler path: the prescaler holds at 0 during the cycle its target is high, so with continuous events there is one tick every P+1 cycles.
- irq_o: exactly one cycle, one cycle after cnt_target_i. Never asserted in ARM or IDLE, except a match that arrives in the same cycle as the transition out of RUN.
- Simultaneous cnt_target_i and stop_i: stop wins the state transition; irq_o is still asserted.
- start_i while in RUN: restarts. The cleared counters and the new shadow values take effect as for a start from IDLE.
- rst_ni asserted mid-operation: immediate return to reset values. No irq is emitted.

## Test plan
- Free-run: presc_en=0, ref_en=0, cmp=4, continuous, cmp_clr=1. Model counters; start_i at cycle 0. Required: cnt_enable_o high from cycle 2; irq_o pulses periodically with a constant period; busy_o=1.
- Prescaled: presc_en=1, P=3. Required: presc_enable_o high every RUN cycle; cnt_enable_o high once every 4 cycles, aligned to presc_target_i.
- Bypass: presc_en=1, P=0. Required: presc_enable_o=0; cnt_enable_o high every cycle.
- One-shot: one_shot=1, cmp=2. Required: a single irq_o pulse; cnt_reset_o in the match cycle; IDLE afterwards; no further enables.
- Ref clock: ref_en=1, ref_clk_i period 10 clk cycles. Required: cnt_enable_o one-cycle pulse 3 cycles after each ref rising edge; no pulse on falling edges.
- Priority/reset: reset_i+stop_i+start_i in one cycle -> IDLE with a one-cycle clear pulse. rst_ni low mid-RUN -> all outputs 0 and IDLE. Changing cfg_cmp_i during RUN does not change cnt_compare_o until the next start_i.

Source files
------------

// File: rtl/timer_unit_sequencer.sv
// Control sequencer for one timer channel: arms and clears the prescaler and
// main counter, derives count ticks, and produces the compare-match interrupt.
module timer_unit_sequencer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        reset_i,
  input  logic        cfg_presc_en_i,
  input  logic [7:0]  cfg_presc_val_i,
  input  logic        cfg_ref_clk_en_i,
  input  logic        cfg_one_shot_i,
  input  logic        cfg_cmp_clr_i,
  input  logic [31:0] cfg_cmp_i,
  input  logic        ref_clk_i,
  input  logic        presc_target_i,
  input  logic        cnt_target_i,
  output logic        presc_reset_o,
  output logic        presc_enable_o,
  output logic [31:0] presc_compare_o,
  output logic        cnt_reset_o,
  output logic        cnt_enable_o,
  output logic [31:0] cnt_compare_o,
  output logic        irq_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e      state_r, state_s;
  logic        presc_en_r;
  logic [7:0]  presc_val_r;
  logic        ref_en_r;
  logic        one_shot_r;
  logic        cmp_clr_r;
  logic [31:0] cmp_r;
  logic [1:0]  ref_sync_r;
  logic        ref_prev_r;
  logic        ref_evt_r;
  logic        clr_pend_r;
  logic        irq_r;
  logic        capture_s;
  logic        evt_s;
  logic        presc_act_s;
  logic        tick_s;

  // reset_i and stop_i both override a simultaneous start_i
  assign capture_s = start_i & ~stop_i & ~reset_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Shadow configuration, only updated by a winning start
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_en_r  <= 1'b0;
      presc_val_r <= 8'd0;
      ref_en_r    <= 1'b0;
      one_shot_r  <= 1'b0;
      cmp_clr_r   <= 1'b0;
      cmp_r       <= 32'd0;
    end else if (capture_s) begin
      presc_en_r  <= cfg_presc_en_i;
      presc_val_r <= cfg_presc_val_i;
      ref_en_r    <= cfg_ref_clk_en_i;
      one_shot_r  <= cfg_one_shot_i;
      cmp_clr_r   <= cfg_cmp_clr_i;
      cmp_r       <= cfg_cmp_i;
    end
  end

  // Reference clock synchroniser and registered rising-edge detector
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_sync_r <= 2'b00;
      ref_prev_r <= 1'b0;
      ref_evt_r  <= 1'b0;
    end else begin
      ref_sync_r <= {ref_sync_r[0], ref_clk_i};
      ref_prev_r <= ref_sync_r[1];
      ref_evt_r  <= ref_sync_r[1] & ~ref_prev_r;
    end
  end

  // Deferred clear pulse after reset_i, and the match interrupt
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clr_pend_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      clr_pend_r <= reset_i;
      irq_r      <= (state_r == ST_RUN) & cnt_target_i;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    if (reset_i || stop_i) begin
      state_s = ST_IDLE;
    end else if (start_i) begin
      state_s = ST_ARM;
    end else begin
      case (state_r)
        ST_IDLE: state_s = ST_IDLE;
        ST_ARM:  state_s = ST_RUN;
        ST_RUN:  state_s = (cnt_target_i && one_shot_r) ? ST_IDLE : ST_RUN;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Counter control outputs
  always_comb begin
    evt_s          = ref_en_r ? ref_evt_r : 1'b1;
    presc_act_s    = presc_en_r & (presc_val_r != 8'd0);
    tick_s         = presc_act_s ? presc_target_i : evt_s;
    presc_reset_o  = clr_pend_r;
    cnt_reset_o    = clr_pend_r;
    presc_enable_o = 1'b0;
    cnt_enable_o   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        presc_enable_o = 1'b0;
        cnt_enable_o   = 1'b0;
      end
      ST_ARM: begin
        presc_reset_o = 1'b1;
        cnt_reset_o   = 1'b1;
      end
      ST_RUN: begin
        presc_enable_o = presc_act_s & evt_s;
        cnt_enable_o   = tick_s;
        cnt_reset_o    = clr_pend_r | (cnt_target_i & (one_shot_r | cmp_clr_r));
      end
      default: begin
        presc_enable_o = 1'b0;
        cnt_enable_o   = 1'b0;
      end
    endcase
  end

  assign presc_compare_o = {24'd0, presc_val_r};
  assign cnt_compare_o   = cmp_r;
  assign irq_o           = irq_r;
  assign busy_o          = (state_r == ST_ARM) || (state_r == ST_RUN);

endmodule

// File: tb/tb_timer_unit_sequencer.sv
// Directed bench for timer_unit_sequencer with small prescaler/main-counter
// models supplying the target pulses.
module tb_timer_unit_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i, stop_i, reset_i;
  logic        cfg_presc_en_i;
  logic [7:0]  cfg_presc_val_i;
  logic        cfg_ref_clk_en_i, cfg_one_shot_i, cfg_cmp_clr_i;
  logic [31:0] cfg_cmp_i;
  logic        ref_clk_i;
  logic        presc_target_i, cnt_target_i;
  logic        presc_reset_o, presc_enable_o, cnt_reset_o, cnt_enable_o;
  logic [31:0] presc_compare_o, cnt_compare_o;
  logic        irq_o, busy_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] m_cnt, m_pc;

  timer_unit_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
    .reset_i(reset_i), .cfg_presc_en_i(cfg_presc_en_i),
    .cfg_presc_val_i(cfg_presc_val_i), .cfg_ref_clk_en_i(cfg_ref_clk_en_i),
    .cfg_one_shot_i(cfg_one_shot_i), .cfg_cmp_clr_i(cfg_cmp_clr_i),
    .cfg_cmp_i(cfg_cmp_i), .ref_clk_i(ref_clk_i),
    .presc_target_i(presc_target_i), .cnt_target_i(cnt_target_i),
    .presc_reset_o(presc_reset_o), .presc_enable_o(presc_enable_o),
    .presc_compare_o(presc_compare_o), .cnt_reset_o(cnt_reset_o),
    .cnt_enable_o(cnt_enable_o), .cnt_compare_o(cnt_compare_o),
    .irq_o(irq_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Main counter model: registered target when the next value reaches compare
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_cnt <= 32'd0;
      cnt_target_i <= 1'b0;
    end else begin
      cnt_target_i <= cnt_enable_o & ~cnt_reset_o & (m_cnt + 32'd1 == cnt_compare_o);
      if (cnt_reset_o) m_cnt <= 32'd0;
      else if (cnt_enable_o) m_cnt <= m_cnt + 32'd1;
    end
  end

  // Prescaler model: holds at 0 during its target cycle, period P+1
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_pc <= 32'd0;
      presc_target_i <= 1'b0;
    end else begin
      presc_target_i <= 1'b0;
      if (presc_reset_o) m_pc <= 32'd0;
      else if (presc_target_i) m_pc <= m_pc;
      else if (presc_enable_o) begin
        if (m_pc == presc_compare_o - 32'd1) begin
          m_pc <= 32'd0;
          presc_target_i <= 1'b1;
        end else begin
          m_pc <= m_pc + 32'd1;
        end
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk_i);
    cyc++;
    #1;
  endtask

  task automatic set_cfg(input logic pe, input logic [7:0] pv, input logic re,
                         input logic os, input logic cc, input logic [31:0] cmp);
    cfg_presc_en_i = pe; cfg_presc_val_i = pv; cfg_ref_clk_en_i = re;
    cfg_one_shot_i = os; cfg_cmp_clr_i = cc; cfg_cmp_i = cmp;
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; stop_i = 1'b0; reset_i = 1'b0; ref_clk_i = 1'b0;
    set_cfg(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    nxt();
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_irq", irq_o, 1'b0);
    chk1("rst_clr", presc_reset_o | cnt_reset_o, 1'b0);
    chk1("rst_en", presc_enable_o | cnt_enable_o, 1'b0);
    chk32("rst_cmp", cnt_compare_o | presc_compare_o, 32'd0);
    rst_ni = 1'b1;
    nxt();

    // Free-run, cmp=4 with clear on match: target in 6, 11, 16; irq one later
    cyc = 0; set_cfg(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 32'd4); start_i = 1'b1;
    nxt(); start_i = 1'b0;
    chk1("arm_busy", busy_o, 1'b1);
    chk1("arm_pclr", presc_reset_o, 1'b1);
    chk1("arm_cclr", cnt_reset_o, 1'b1);
    chk1("arm_cen", cnt_enable_o, 1'b0);
    chk32("arm_cmp", cnt_compare_o, 32'd4);
    nxt();
    chk1("run_cen", cnt_enable_o, 1'b1);
    chk1("run_pen", presc_enable_o, 1'b0);
    chk1("run_cclr", cnt_reset_o, 1'b0);
    while (cyc < 17) begin
      nxt();
      chk1("fr_irq", irq_o, (cyc == 7) || (cyc == 12) || (cyc == 17));
      chk1("fr_cclr", cnt_reset_o, (cyc == 6) || (cyc == 11) || (cyc == 16));
      chk1("fr_busy", busy_o, 1'b1);
      chk1("fr_cen", cnt_enable_o, 1'b1);
    end

    // Restart into prescaled mode, P=3: ticks at 5, 9, 13, 17
    nxt(); cyc = 0;
    set_cfg(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 32'd100); start_i = 1'b1;
    nxt(); start_i = 1'b0;
    chk1("ps_arm_pclr", presc_reset_o, 1'b1);
    while (cyc < 17) begin
      nxt();
      chk1("ps_pen", presc_enable_o, 1'b1);
      chk1("ps_cen", cnt_enable_o, (cyc >= 5) && (cyc % 4 == 1));
      if (cyc == 6) begin
        cfg_cmp_i = 32'd7; cfg_presc_val_i = 8'd1;
      end
      if (cyc == 8) begin
        chk32("shadow_cmp", cnt_compare_o, 32'd100);
        chk32("shadow_psc", presc_compare_o, 32'd3);
      end
    end
    nxt(); stop_i = 1'b1;
    nxt(); stop_i = 1'b0;
    chk1("stop_busy", busy_o, 1'b0);
    chk1("stop_en", presc_enable_o | cnt_enable_o, 1'b0);
    chk1("stop_noclr", presc_reset_o | cnt_reset_o, 1'b0);

    // Bypass: prescaler enabled but P=0
    nxt(); cyc = 0;
    set_cfg(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 32'd1000); start_i = 1'b1;
    nxt(); start_i = 1'b0;
    while (cyc < 6) begin
      nxt();
      chk1("byp_pen", presc_enable_o, 1'b0);
      chk1("byp_cen", cnt_enable_o, 1'b1);
    end

    // One-shot, cmp=2: target in 4, irq in 5, idle afterwards
    nxt(); cyc = 0;
    set_cfg(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 32'd2); start_i = 1'b1;
    nxt(); start_i = 1'b0;
    while (cyc < 10) begin
      nxt();
      chk1("os_irq", irq_o, cyc == 5);
      chk1("os_cclr", cnt_reset_o, cyc == 4);
      chk1("os_busy", busy_o, cyc <= 4);
      chk1("os_cen", cnt_enable_o, cyc <= 4);
    end

    // Reference clock, period 10 cycles, rising in 5, 15, 25, 35
    nxt(); cyc = 0;
    set_cfg(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 32'd1000); start_i = 1'b1;
    nxt(); start_i = 1'b0;
    while (cyc < 40) begin
      nxt();
      ref_clk_i = ((cyc / 5) % 2 == 1);
      chk1("ref_cen", cnt_enable_o, cyc % 10 == 8);
      chk1("ref_pen", presc_enable_o, 1'b0);
    end

    // reset_i + stop_i + start_i together
    nxt(); reset_i = 1'b1; stop_i = 1'b1; start_i = 1'b1;
    nxt(); reset_i = 1'b0; stop_i = 1'b0; start_i = 1'b0;
    chk1("pri_busy", busy_o, 1'b0);
    chk1("pri_pclr", presc_reset_o, 1'b1);
    chk1("pri_cclr", cnt_reset_o, 1'b1);
    chk1("pri_cen", cnt_enable_o, 1'b0);
    nxt();
    chk1("pri_clr_end", presc_reset_o | cnt_reset_o, 1'b0);
    chk1("pri_busy2", busy_o, 1'b0);

    // stop_i in the match cycle: go idle, irq still fires
    nxt(); cyc = 0;
    set_cfg(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 32'd4); start_i = 1'b1;
    nxt(); start_i = 1'b0;
    while (cyc < 6) nxt();
    chk1("sm_cclr", cnt_reset_o, 1'b1);
    stop_i = 1'b1;
    nxt(); stop_i = 1'b0;
    chk1("sm_irq", irq_o, 1'b1);
    chk1("sm_busy", busy_o, 1'b0);
    nxt();
    chk1("sm_irq_end", irq_o, 1'b0);

    // rst_ni asserted in the match cycle: no irq
    nxt(); cyc = 0; start_i = 1'b1;
    nxt(); start_i = 1'b0;
    while (cyc < 6) nxt();
    chk1("ar_pre_cclr", cnt_reset_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk1("ar_busy", busy_o, 1'b0);
    chk1("ar_clr", presc_reset_o | cnt_reset_o, 1'b0);
    chk1("ar_en", presc_enable_o | cnt_enable_o, 1'b0);
    chk32("ar_cmp", cnt_compare_o, 32'd0);
    nxt();
    chk1("ar_irq", irq_o, 1'b0);
    rst_ni = 1'b1;
    nxt();
    chk1("ar_irq2", irq_o, 1'b0);
    chk1("ar_busy2", busy_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
